// File: rtl/conv2d_pkg.sv
// Shared types and constants for the conv2d result writer.
package conv2d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 18;
  localparam int DEF_MAP_W      = 224;
  localparam int DEF_MAP_H      = 224;
  localparam int DEF_FIFO_DEPTH = 8;

  // Number of output pixels in one map.
  function automatic int map_pixels(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
// DEPTH must be a power of two so the pointers wrap naturally.
module result_fifo
  import conv2d_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when a pop frees the slot the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointer, occupancy and storage next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control registers, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are meaningless while empty so it is not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/conv2d_result_writer.sv
// Sink of the conv2d pipeline: buffers the unstallable result stream and
// writes one output map to memory at linear addresses from base_addr.
// Optional build macro: RESULT_RELU_EN clamps negative results to zero.
//
// state | meaning
// IDLE  | waiting for start, any valid_in is a lost sample
// RUN   | accepting map samples and writing them out
// DRAIN | all samples seen, flushing the FIFO to memory
module conv2d_result_writer
  import conv2d_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int MAP_W      = DEF_MAP_W,
  parameter int MAP_H      = DEF_MAP_H,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_ready,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int PIX   = map_pixels(MAP_W, MAP_H);
  localparam int CNT_W = $clog2(PIX + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] PIX_C = CNT_W'(PIX);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic              active, push, pop;
  logic [DATA_W-1:0] push_data, fifo_head;
  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;

  assign active = (state_q != IDLE);
  assign pop    = wr_valid && wr_ready;
  // A full FIFO still accepts a sample when the head leaves the same cycle.
  assign push   = (state_q == RUN) && valid_in && (!fifo_full || pop);

`ifdef RESULT_RELU_EN
  assign push_data = data_in[DATA_W-1] ? '0 : data_in;
`else
  assign push_data = data_in;
`endif

  result_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Next-state, counters and status flags.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    base_d    = base_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) ovf_d = 1'b1;
        if (start) begin
          state_d   = RUN;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          base_d    = base_addr;
          ovf_d     = 1'b0;
        end
      end
      RUN: begin
        if (valid_in) begin
          // Dropped samples still advance in_cnt so the map geometry holds.
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (!push) ovf_d = 1'b1;
          if (in_cnt_q + CNT_W'(1) == PIX_C) state_d = DRAIN;
        end
        if (pop) out_cnt_d = out_cnt_q + CNT_W'(1);
      end
      DRAIN: begin
        if (valid_in) ovf_d = 1'b1;
        if (pop) begin
          out_cnt_d = out_cnt_q + CNT_W'(1);
          // After dropped samples out_cnt never reaches the map size, so the
          // write that empties the FIFO also ends the map.
          if ((out_cnt_q + CNT_W'(1) == PIX_C) || (fifo_level == LVL_W'(1))) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      base_q    <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      base_q    <= base_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign wr_valid = active && !fifo_empty;
  assign wr_addr  = base_q + ADDR_W'(out_cnt_q);
  assign wr_data  = wr_valid ? fifo_head : '0;
  assign busy     = active;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
